// File: rtl/decode_stage_pkg.sv
// Shared types and encodings for the RV32I decode stage.
// Control word, ALU operation and instruction format enums plus opcode/funct constants.
package decode_stage_pkg;

  typedef logic [31:0] instruction_type;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_PASS_B
  } alu_op_type;

  typedef enum logic [2:0] {
    R_TYPE,
    I_TYPE,
    S_TYPE,
    B_TYPE,
    U_TYPE,
    J_TYPE
  } encoding_type;

  typedef struct packed {
    alu_op_type   alu_op;
    encoding_type encoding;
    logic         alu_src;
    logic         mem_read;
    logic         mem_write;
    logic         mem_to_reg;
    logic         reg_write;
    logic         is_branch;
    logic         branch_ne;
    logic         is_jump;
    logic         link;
  } control_type;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: selects the immediate field by format and
// sign-extends it to XLEN. R-type (and anything undecoded) yields zero.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]      instruction,
  input  encoding_type     encoding,
  output logic [XLEN-1:0]  imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (encoding)
      I_TYPE:  imm32 = {{20{instruction[31]}}, instruction[31:20]};
      S_TYPE:  imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      B_TYPE:  imm32 = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                        instruction[11:8], 1'b0};
      J_TYPE:  imm32 = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                        instruction[30:21], 1'b0};
      U_TYPE:  imm32 = {instruction[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end

  // signed source, so widening to XLEN=64 sign-extends
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes one instruction per accepted handshake,
// stalls on load-use hazards, honours flush and counts illegal encodings.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int EXT_ALU       = 1,
  parameter int HAZARD_DETECT = 1,
  parameter int ILL_CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  instruction_type       instruction,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  ex_mem_read,
  input  logic [4:0]            ex_rd,
  output control_type           control,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic [XLEN-1:0]       imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  illegal,
  output logic [ILL_CNT_W-1:0]  ill_count
);

  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [4:0]      rs1_in;
  logic [4:0]      rs2_in;
  logic [4:0]      rd_in;
  logic            ext_ok;
  control_type     dec;
  logic            dec_illegal;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] imm_dec;

  assign opcode = instruction[6:0];
  assign rd_in  = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1_in = instruction[19:15];
  assign rs2_in = instruction[24:20];
  assign funct7 = instruction[31:25];
  assign ext_ok = (EXT_ALU != 0);

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.encoding  = R_TYPE;
        dec.reg_write = 1'b1;
        if (funct7 == F7_SUB) begin
          if (funct3 == F3_ADD_SUB) dec.alu_op = ALU_SUB;
          else                      dec_illegal = 1'b1;
        end else if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD_SUB: dec.alu_op = ALU_ADD;
            F3_AND:     begin dec.alu_op = ALU_AND; dec_illegal = !ext_ok; end
            F3_OR:      begin dec.alu_op = ALU_OR;  dec_illegal = !ext_ok; end
            F3_XOR:     begin dec.alu_op = ALU_XOR; dec_illegal = !ext_ok; end
            F3_SLT:     begin dec.alu_op = ALU_SLT; dec_illegal = !ext_ok; end
            default:    dec_illegal = 1'b1;
          endcase
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.encoding  = I_TYPE;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        case (funct3)
          F3_ADD_SUB: dec.alu_op = ALU_ADD;
          F3_AND:     begin dec.alu_op = ALU_AND; dec_illegal = !ext_ok; end
          F3_OR:      begin dec.alu_op = ALU_OR;  dec_illegal = !ext_ok; end
          F3_XOR:     begin dec.alu_op = ALU_XOR; dec_illegal = !ext_ok; end
          default:    dec_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.encoding   = I_TYPE;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        dec_illegal    = (funct3 != F3_LW);
      end
      OPC_STORE: begin
        dec.encoding  = S_TYPE;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec_illegal   = (funct3 != F3_SW);
      end
      OPC_BRANCH: begin
        dec.encoding  = B_TYPE;
        dec.alu_op    = ALU_SUB;
        dec.is_branch = 1'b1;
        dec.branch_ne = (funct3 == F3_BNE);
        dec_illegal   = (funct3 != F3_BEQ) && (funct3 != F3_BNE);
      end
      OPC_JAL: begin
        dec.encoding  = J_TYPE;
        dec.is_jump   = 1'b1;
        dec.reg_write = 1'b1;
        dec.link      = 1'b1;
      end
      OPC_LUI: begin
        dec.encoding  = U_TYPE;
        dec.alu_op    = ALU_PASS_B;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) dec = '0;
  end

  // undecodable words read no registers, so they never stall
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    if (!dec_illegal) begin
      case (dec.encoding)
        R_TYPE, S_TYPE, B_TYPE: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
        I_TYPE:                 uses_rs1 = 1'b1;
        default:                ;
      endcase
    end
  end

  assign hazard = (HAZARD_DETECT != 0) && in_valid && ex_mem_read && (ex_rd != 5'd0) &&
                  ((uses_rs1 && (rs1_in == ex_rd)) || (uses_rs2 && (rs2_in == ex_rd)));

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  decode_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instruction (instruction[31:7]),
    .encoding    (dec.encoding),
    .imm         (imm_dec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      control   <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      imm       <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      control   <= dec;
      rs1       <= rs1_in;
      rs2       <= rs2_in;
      rd        <= dec.reg_write ? rd_in : 5'd0;
      imm       <= imm_dec;
      out_valid <= 1'b1;
      illegal   <= dec_illegal;
    end else if (!out_valid || out_ready || flush) begin
      control   <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      imm       <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ill_count <= '0;
    end else if (accept && dec_illegal && (ill_count != '1)) begin
      ill_count <= ill_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed steps followed by random traffic,
// all compared against a field-level reference decoder and handshake model.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instruction = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, illegal;
  control_type control;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic [7:0]  ill_count;

  logic        n_in_ready, n_out_valid, n_illegal;
  control_type n_control;
  logic [4:0]  n_rs1, n_rs2, n_rd;
  logic [31:0] n_imm;
  logic [7:0]  n_ill_count;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .EXT_ALU(1), .HAZARD_DETECT(1), .ILL_CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .control(control), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .illegal(illegal), .ill_count(ill_count)
  );

  decode_stage #(.XLEN(32), .EXT_ALU(0), .HAZARD_DETECT(1), .ILL_CNT_W(8)) dut_noext (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .in_valid(in_valid),
    .in_ready(n_in_ready), .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .control(n_control), .rs1(n_rs1), .rs2(n_rs2), .rd(n_rd), .imm(n_imm),
    .out_valid(n_out_valid), .out_ready(out_ready), .illegal(n_illegal),
    .ill_count(n_ill_count)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    control_type ctrl;
    logic        ill;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        u1;
    logic        u2;
  } dec_t;

  // expected stage contents
  logic        m_valid;
  control_type m_ctrl;
  logic        m_ill;
  logic [31:0] m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  int          m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sext(input longint v, input int bits);
    longint half, full;
    half = longint'(1) << (bits - 1);
    full = longint'(1) << bits;
    return (v >= half) ? v - full : v;
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] i, input bit ext);
    dec_t        d;
    control_type c;
    bit          ok;
    int          op, f3, f7, key;
    longint      v;
    op = int'(i[6:0]); f3 = int'(i[14:12]); f7 = int'(i[31:25]);
    key = f7 * 8 + f3;
    c = '0; d = '0; ok = 1'b1; v = 0;
    case (op)
      'h33: begin
        c.encoding = R_TYPE; c.reg_write = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1;
        case (key)
          0:       c.alu_op = ALU_ADD;
          256:     c.alu_op = ALU_SUB;
          7:       begin c.alu_op = ALU_AND; ok = ext; end
          6:       begin c.alu_op = ALU_OR;  ok = ext; end
          4:       begin c.alu_op = ALU_XOR; ok = ext; end
          2:       begin c.alu_op = ALU_SLT; ok = ext; end
          default: ok = 1'b0;
        endcase
      end
      'h13: begin
        c.encoding = I_TYPE; c.reg_write = 1'b1; c.alu_src = 1'b1; d.u1 = 1'b1;
        v = sext(longint'(i[31:20]), 12);
        case (f3)
          0:       c.alu_op = ALU_ADD;
          7:       begin c.alu_op = ALU_AND; ok = ext; end
          6:       begin c.alu_op = ALU_OR;  ok = ext; end
          4:       begin c.alu_op = ALU_XOR; ok = ext; end
          default: ok = 1'b0;
        endcase
      end
      'h03: begin
        c.encoding = I_TYPE; c.reg_write = 1'b1; c.alu_src = 1'b1;
        c.mem_read = 1'b1; c.mem_to_reg = 1'b1; d.u1 = 1'b1;
        v = sext(longint'(i[31:20]), 12);
        ok = (f3 == 2);
      end
      'h23: begin
        c.encoding = S_TYPE; c.alu_src = 1'b1; c.mem_write = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1;
        v = sext(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
        ok = (f3 == 2);
      end
      'h63: begin
        c.encoding = B_TYPE; c.alu_op = ALU_SUB; c.is_branch = 1'b1; c.branch_ne = (f3 == 1);
        d.u1 = 1'b1; d.u2 = 1'b1;
        v = sext(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
                 longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
        ok = (f3 == 0) || (f3 == 1);
      end
      'h6F: begin
        c.encoding = J_TYPE; c.is_jump = 1'b1; c.reg_write = 1'b1; c.link = 1'b1;
        v = sext(longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 +
                 longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
      end
      'h37: begin
        c.encoding = U_TYPE; c.alu_op = ALU_PASS_B; c.alu_src = 1'b1; c.reg_write = 1'b1;
        v = longint'(i & 32'hFFFF_F000);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      c = '0; v = 0; d.u1 = 1'b0; d.u2 = 1'b0;
    end
    d.ctrl = c;
    d.ill  = !ok;
    d.imm  = 32'(v);
    d.rs1  = i[19:15];
    d.rs2  = i[24:20];
    d.rd   = c.reg_write ? i[11:7] : 5'd0;
    return d;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = '0; m_ill = 1'b0; m_imm = '0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_cnt = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("control", control, m_ctrl);
    chk("illegal", 64'(illegal), 64'(m_ill));
    chk("ill_count", 64'(ill_count), 64'(m_cnt));
    if (m_valid) begin
      chk("rs1", 64'(rs1), 64'(m_rs1));
      chk("rs2", 64'(rs2), 64'(m_rs2));
      chk("rd", 64'(rd), 64'(m_rd));
      chk("imm", 64'(imm), 64'(m_imm));
    end
  endtask

  // one clock: check in_ready before the edge, advance the model, check after
  task automatic cycle();
    dec_t d;
    logic hz, rdy;
    #1;
    d  = ref_decode(instruction, 1'b1);
    hz = in_valid && ex_mem_read && (ex_rd != 5'd0) &&
         ((d.u1 && (instruction[19:15] == ex_rd)) || (d.u2 && (instruction[24:20] == ex_rd)));
    rdy = (!m_valid || out_ready) && !hz && !flush;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    @(posedge clk);
    #1;
    if (in_valid && rdy) begin
      m_valid = 1'b1; m_ctrl = d.ctrl; m_ill = d.ill; m_imm = d.imm;
      m_rs1 = d.rs1; m_rs2 = d.rs2; m_rd = d.rd;
      if (d.ill && m_cnt < 255) m_cnt++;
    end else if (!m_valid || out_ready || flush) begin
      m_valid = 1'b0; m_ctrl = '0; m_ill = 1'b0;
    end
    check_outputs();
  endtask

  task automatic drive(input logic [31:0] inst, input logic v, input logic ordy,
                       input logic exmr, input logic [4:0] exrd, input logic fl);
    instruction = inst; in_valid = v; out_ready = ordy;
    ex_mem_read = exmr; ex_rd = exrd; flush = fl;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    logic [6:0]  ops [7];
    logic [2:0]  f3s [6];
    int          k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37};
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd6, 3'd7};
    i = $urandom();
    k = int'($urandom_range(0, 7));
    if (k < 7) i[6:0] = ops[k];
    if ($urandom_range(0, 3) != 0) i[14:12] = f3s[$urandom_range(0, 5)];
    if ($urandom_range(0, 3) != 0) i[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  initial begin
    model_reset();
    #12;
    check_outputs();
    chk("reset_imm", 64'(imm), 64'd0);
    chk("reset_rd", 64'(rd), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // ADD x3,x1,x2
    drive(32'h002081B3, 1, 1, 0, 0, 0); cycle();
    chk("add_alu", 64'(control.alu_op), 64'(ALU_ADD));
    chk("add_rd", 64'(rd), 64'd3);

    // ADDI x1,x0,-1 then BEQ x0,x0,-4
    drive(32'hFFF00093, 1, 1, 0, 0, 0); cycle();
    chk("addi_imm", 64'(imm), 64'hFFFF_FFFF);
    drive(32'hFE000EE3, 1, 1, 0, 0, 0); cycle();
    chk("beq_imm", 64'(imm), 64'hFFFF_FFFC);
    chk("beq_rd", 64'(rd), 64'd0);

    // load-use: LW x5 then ADD x6,x5,x5 stalls one cycle
    drive(32'h0080A283, 1, 1, 0, 0, 0); cycle();
    drive(32'h00528333, 1, 1, 1, 5, 0); cycle();
    chk("hazard_bubble", 64'(out_valid), 64'd0);
    drive(32'h00528333, 1, 1, 0, 5, 0); cycle();
    chk("after_stall_rd", 64'(rd), 64'd6);

    // back-pressure for three cycles, then release
    drive(32'h40208133, 1, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) cycle();
    chk("hold_rd", 64'(rd), 64'd6);
    drive(32'h40208133, 1, 1, 0, 0, 0); cycle();
    chk("sub_alu", 64'(control.alu_op), 64'(ALU_SUB));

    // illegal word, counter saturation
    drive(32'h0000_0000, 1, 1, 0, 0, 0);
    for (int n = 0; n < 300; n++) cycle();
    chk("ill_sat", 64'(ill_count), 64'd255);

    // AND x1,x2,x3 with and without the extension
    drive(32'h003170B3, 1, 1, 0, 0, 0); cycle();
    chk("and_alu", 64'(control.alu_op), 64'(ALU_AND));
    chk("noext_valid", 64'(n_out_valid), 64'd1);
    chk("noext_illegal", 64'(n_illegal), 64'd1);
    chk("noext_control", n_control, 64'd0);
    drive(32'h0FF17093, 1, 1, 0, 0, 0); cycle();
    chk("noext_andi_illegal", 64'(n_illegal), 64'd1);
    chk("ext_andi_illegal", 64'(illegal), 64'd0);

    // flush kills a held output and refuses the input
    drive(32'h002081B3, 1, 1, 0, 0, 0); cycle();
    drive(32'h0080A283, 1, 0, 0, 0, 1); cycle();
    chk("flush_valid", 64'(out_valid), 64'd0);
    drive(32'h0080A283, 1, 1, 0, 0, 0); cycle();
    chk("after_flush_lw", 64'(control.mem_read), 64'd1);

    // reset while stalled and held
    drive(32'h0080A283, 1, 1, 0, 0, 0); cycle();
    drive(32'h00528333, 1, 0, 1, 5, 0); cycle();
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_imm", 64'(imm), 64'd0);
    chk("rst_rs1", 64'(rs1), 64'd0);
    chk("rst_rs2", 64'(rs2), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      drive(rand_inst(), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) != 0, 5'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
